// File: rtl/lcd_cmd_sequencer.sv
// HD44780 4-bit-mode sequencer: power-on init, nibble split, enable strobes and execution delays.
// Optional 2x16 cursor tracking with automatic line wrap when LCD_LINE_WRAP_EN is defined.
module lcd_cmd_sequencer #(
  parameter int EN_PULSE_CYC   = 12,
  parameter int SHORT_WAIT_CYC = 600,
  parameter int LONG_WAIT_CYC  = 24000,
  parameter int POWERUP_CYC    = 180000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [3:0] lcd_data
);

  localparam int MAX_CYC = (POWERUP_CYC > LONG_WAIT_CYC) ? POWERUP_CYC : LONG_WAIT_CYC;
  localparam int CNT_W   = ($clog2(MAX_CYC + 1) > 18) ? $clog2(MAX_CYC + 1) : 18;

  localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(SHORT_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    PWR_WAIT, INIT_NIB, INIT_BYTE, IDLE, SETUP, EN_HI, EN_LO, POST_WAIT
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       step_reg, step_next;
  logic             init_bytes_reg, init_bytes_next;
  logic [3:0]       lo_nib_reg, lo_nib_next;
  logic             nib_lo_reg, nib_lo_next;
  logic             single_reg, single_next;
  logic             long_reg, long_next;
  logic             init_done_reg, init_done_next;
  logic             lcd_rs_reg, lcd_rs_next;
  logic [3:0]       lcd_data_reg, lcd_data_next;

  logic             load_en, load_rs;
  logic [7:0]       load_data;
  logic             accept;

`ifdef LCD_LINE_WRAP_EN
  logic [3:0]       col_reg, col_next;
  logic             line_reg, line_next;
  logic             wrap_reg, wrap_next;
`endif

  function automatic logic is_long(input logic rs, input logic [7:0] d);
    return !rs && (d == 8'h01 || d == 8'h02 || d == 8'h03);
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] s);
    case (s)
      2'd0:    return 8'h28;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  assign req_ready = init_done_reg && (state_reg == IDLE);
  assign accept    = req_valid && req_ready;
  assign init_done = init_done_reg;
  assign busy      = (state_reg != IDLE) && !rst;
  assign lcd_en    = (state_reg == EN_HI);
  assign lcd_rs    = lcd_rs_reg;
  assign lcd_data  = lcd_data_reg;

  always_comb begin
    state_next      = state_reg;
    step_next       = step_reg;
    init_bytes_next = init_bytes_reg;
    lo_nib_next     = lo_nib_reg;
    nib_lo_next     = nib_lo_reg;
    single_next     = single_reg;
    long_next       = long_reg;
    init_done_next  = init_done_reg;
    lcd_rs_next     = lcd_rs_reg;
    lcd_data_next   = lcd_data_reg;
    load_en         = 1'b0;
    load_rs         = 1'b0;
    load_data       = 8'h00;
`ifdef LCD_LINE_WRAP_EN
    col_next        = col_reg;
    line_next       = line_reg;
    wrap_next       = wrap_reg;
`endif

    case (state_reg)
      PWR_WAIT: if (cnt_reg == PWR_LAST) state_next = INIT_NIB;
      INIT_NIB: begin
        // Single-nibble wake-up writes; every one is followed by the long wait.
        lcd_rs_next   = 1'b0;
        lcd_data_next = (step_reg == 2'd3) ? 4'h2 : 4'h3;
        single_next   = 1'b1;
        long_next     = 1'b1;
        state_next    = SETUP;
      end
      INIT_BYTE: begin
        load_en   = 1'b1;
        load_data = init_byte(step_reg);
      end
      IDLE: if (accept) begin
        load_en   = 1'b1;
        load_rs   = req_rs;
        load_data = req_data;
`ifdef LCD_LINE_WRAP_EN
        if (req_rs) begin
          if (col_reg == 4'hF) wrap_next = 1'b1;
          else                 col_next  = col_reg + 4'd1;
        end else if (req_data == 8'h01 || req_data == 8'h02) begin
          col_next  = 4'h0;
          line_next = 1'b0;
        end else if (req_data[7]) begin
          if (req_data[6:4] == 3'b000) begin
            line_next = 1'b0;
            col_next  = req_data[3:0];
          end else if (req_data[6:4] == 3'b100) begin
            line_next = 1'b1;
            col_next  = req_data[3:0];
          end
        end
`endif
      end
      SETUP: state_next = EN_HI;
      EN_HI: if (cnt_reg == EN_LAST) state_next = EN_LO;
      EN_LO: if (cnt_reg == EN_LAST) begin
        if (single_reg || nib_lo_reg) begin
          state_next = POST_WAIT;
        end else begin
          nib_lo_next   = 1'b1;
          lcd_data_next = lo_nib_reg;
          state_next    = SETUP;
        end
      end
      POST_WAIT: if (cnt_reg == (long_reg ? LONG_LAST : SHORT_LAST)) begin
        if (!init_done_reg) begin
          step_next = step_reg + 2'd1;
          if (!init_bytes_reg) begin
            if (step_reg == 2'd3) begin
              init_bytes_next = 1'b1;
              state_next      = INIT_BYTE;
            end else begin
              state_next = INIT_NIB;
            end
          end else if (step_reg == 2'd3) begin
            init_done_next = 1'b1;
            state_next     = IDLE;
`ifdef LCD_LINE_WRAP_EN
            col_next  = 4'h0;
            line_next = 1'b0;
            wrap_next = 1'b0;
`endif
          end else begin
            state_next = INIT_BYTE;
          end
        end else begin
`ifdef LCD_LINE_WRAP_EN
          // Wrap: jump the DDRAM address to the start of the other line before reopening.
          if (wrap_reg) begin
            load_en   = 1'b1;
            load_data = line_reg ? 8'h80 : 8'hC0;
            wrap_next = 1'b0;
            col_next  = 4'h0;
            line_next = !line_reg;
          end else begin
            state_next = IDLE;
          end
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = PWR_WAIT;
    endcase

    if (load_en) begin
      lcd_rs_next   = load_rs;
      lcd_data_next = load_data[7:4];
      lo_nib_next   = load_data[3:0];
      nib_lo_next   = 1'b0;
      single_next   = 1'b0;
      long_next     = is_long(load_rs, load_data);
      state_next    = SETUP;
    end

    // One shared counter: restarts on every state change, parked at zero in IDLE.
    cnt_next = (state_next != state_reg || state_reg == IDLE) ? '0 : cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= PWR_WAIT;
      cnt_reg        <= '0;
      step_reg       <= 2'd0;
      init_bytes_reg <= 1'b0;
      lo_nib_reg     <= 4'h0;
      nib_lo_reg     <= 1'b0;
      single_reg     <= 1'b0;
      long_reg       <= 1'b0;
      init_done_reg  <= 1'b0;
      lcd_rs_reg     <= 1'b0;
      lcd_data_reg   <= 4'h0;
`ifdef LCD_LINE_WRAP_EN
      col_reg        <= 4'h0;
      line_reg       <= 1'b0;
      wrap_reg       <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      step_reg       <= step_next;
      init_bytes_reg <= init_bytes_next;
      lo_nib_reg     <= lo_nib_next;
      nib_lo_reg     <= nib_lo_next;
      single_reg     <= single_next;
      long_reg       <= long_next;
      init_done_reg  <= init_done_next;
      lcd_rs_reg     <= lcd_rs_next;
      lcd_data_reg   <= lcd_data_next;
`ifdef LCD_LINE_WRAP_EN
      col_reg        <= col_next;
      line_reg       <= line_next;
      wrap_reg       <= wrap_next;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Randomized bench for lcd_cmd_sequencer: pin-level nibble monitor checked against a queue-based model.
module tb_lcd_cmd_sequencer;

  localparam int EN = 4;
  localparam int SH = 25;
  localparam int LG = 70;
  localparam int PW = 200;
  localparam int BYTE_CYC = 2 * (1 + 2 * EN);
  localparam int BIG = 32'h7fffffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, init_done, busy, lcd_rs, lcd_en;
  logic [3:0] lcd_data;

  lcd_cmd_sequencer #(
    .EN_PULSE_CYC(EN), .SHORT_WAIT_CYC(SH), .LONG_WAIT_CYC(LG), .POWERUP_CYC(PW)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
    .req_ready(req_ready), .init_done(init_done), .busy(busy),
    .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [3:0] nib;
    int         gmin;
    int         gmax;
  } nib_t;

  nib_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_wait = 0;
  int   col = 0;
  logic line = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int wait_of(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? LG : SH;
  endfunction

  // Expected enable pulses, with the allowed spacing from the previous rising edge.
  task automatic push_byte(input logic rs, input logic [7:0] d, input bit tight);
    nib_t e;
    e.rs = rs; e.nib = d[7:4];
    e.gmin = 2 * EN + last_wait + 1;
    e.gmax = tight ? e.gmin + 3 : BIG;
    exp_q.push_back(e);
    e.nib = d[3:0];
    e.gmin = 2 * EN + 1;
    e.gmax = e.gmin;
    exp_q.push_back(e);
    last_wait = wait_of(rs, d);
  endtask

  task automatic push_init();
    nib_t e;
    logic [7:0] ib [4];
    ib[0] = 8'h28; ib[1] = 8'h0C; ib[2] = 8'h01; ib[3] = 8'h06;
    e.rs = 1'b0; e.nib = 4'h3; e.gmin = PW; e.gmax = PW + 4;
    exp_q.push_back(e);
    for (int i = 1; i < 4; i++) begin
      e.nib = (i == 3) ? 4'h2 : 4'h3;
      e.gmin = 2 * EN + LG + 1;
      e.gmax = e.gmin + 3;
      exp_q.push_back(e);
    end
    last_wait = LG;
    for (int i = 0; i < 4; i++) push_byte(1'b0, ib[i], 1'b1);
    col = 0;
    line = 1'b0;
  endtask

  task automatic model_accept(input logic rs, input logic [7:0] d, output int lo, output int hi);
    push_byte(rs, d, 1'b0);
    lo = BYTE_CYC + wait_of(rs, d);
    hi = lo;
`ifdef LCD_LINE_WRAP_EN
    if (rs) begin
      if (col == 15) begin
        push_byte(1'b0, line ? 8'h80 : 8'hC0, 1'b1);
        lo = lo + BYTE_CYC + SH;
        hi = lo + 1;
        col = 0;
        line = !line;
      end else begin
        col++;
      end
    end else if (d == 8'h01 || d == 8'h02) begin
      col = 0;
      line = 1'b0;
    end else if (d[7]) begin
      if (d[6:0] <= 7'h0F) begin
        line = 1'b0; col = d[3:0];
      end else if (d[6:0] >= 7'h40 && d[6:0] <= 7'h4F) begin
        line = 1'b1; col = d[3:0];
      end
    end
`endif
  endtask

  // Pin monitor: each enable pulse is matched against the head of the expected queue.
  int         prev_rise = 0, p_rise = 0, p_gap = 0;
  logic       in_pulse = 1'b0, p_rs = 1'b0, p_unstable = 1'b0;
  logic [3:0] p_nib = 4'h0;

  always @(negedge clk) begin
    if (rst) begin
      prev_rise = cyc;
      in_pulse  = 1'b0;
    end else if (lcd_en && !in_pulse) begin
      in_pulse   = 1'b1;
      p_rise     = cyc;
      p_gap      = cyc - prev_rise;
      prev_rise  = cyc;
      p_nib      = lcd_data;
      p_rs       = lcd_rs;
      p_unstable = 1'b0;
    end else if (lcd_en && in_pulse) begin
      if (lcd_data !== p_nib || lcd_rs !== p_rs) p_unstable = 1'b1;
    end else if (!lcd_en && in_pulse) begin
      in_pulse = 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {28'h0, p_nib}, 32'hFFFF_FFFF);
      end else begin
        nib_t e;
        e = exp_q.pop_front();
        chk("nibble", p_nib, e.nib);
        chk("rs", p_rs, e.rs);
        chk("en_width", cyc - p_rise, EN);
        chk("data_stable", p_unstable, 0);
        if (e.gmin == e.gmax) chk("gap", p_gap, e.gmin);
        else                  chk("gap_range", (p_gap >= e.gmin) && (p_gap <= e.gmax), 1);
      end
    end
  end

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("init_timeout", n < 40000, 1);
    chk("init_q_empty", exp_q.size(), 0);
    chk("init_done_delay", (cyc - prev_rise >= 2 * EN + SH) && (cyc - prev_rise <= 2 * EN + SH + 2), 1);
    chk("ready_after_init", req_ready, 1);
    $display("init done at cycle %0d", cyc);
  endtask

  task automatic do_init();
    push_init();
    @(posedge clk);
    #1 rst = 1'b0;
    wait_init();
  endtask

  // Must be entered at a falling edge; returns at the falling edge where req_ready is back high.
  task automatic xfer(input logic rs, input logic [7:0] d, input bit hold,
                      input logic nrs, input logic [7:0] nd, output int acc_wait);
    int lo, hi, n;
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    acc_wait  = 0;
    while (!req_ready && acc_wait < 20000) begin
      @(negedge clk);
      acc_wait++;
    end
    chk("accept_timeout", acc_wait < 20000, 1);
    model_accept(rs, d, lo, hi);
    @(posedge clk);
    #1;
    if (hold) begin
      req_rs   = nrs;
      req_data = nd;
    end else begin
      req_valid = 1'b0;
    end
    n = 0;
    @(negedge clk);
    chk("busy_during_xfer", busy, 1);
    while (!req_ready && n < 20000) begin
      n++;
      if (!hold) begin
        req_valid = (n < 2 * EN) ? 1'($urandom_range(0, 1)) : 1'b0;
        req_rs    = 1'($urandom_range(0, 1));
        req_data  = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
    end
    if (lo == hi) chk("ready_low_cycles", n, lo);
    else          chk("ready_low_range", (n >= lo) && (n <= hi), 1);
    chk("busy_idle", busy, 0);
    chk("init_done_held", init_done, 1);
    $display("xfer rs=%0d data=%02h accept_wait=%0d ready_low=%0d", rs, d, acc_wait, n);
  endtask

  initial begin
    int w;
    logic [7:0] cmd_tab [8];
    logic [7:0] d;
    logic r;
    cmd_tab[0] = 8'h01; cmd_tab[1] = 8'h02; cmd_tab[2] = 8'h03; cmd_tab[3] = 8'h0C;
    cmd_tab[4] = 8'h06; cmd_tab[5] = 8'h80; cmd_tab[6] = 8'hC0; cmd_tab[7] = 8'h0E;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_lcd_en", lcd_en, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_data", lcd_data, 0);

    do_init();

    xfer(1'b1, 8'h48, 1'b0, 1'b0, 8'h00, w);
    xfer(1'b0, 8'h01, 1'b0, 1'b0, 8'h00, w);
    xfer(1'b0, 8'h0C, 1'b0, 1'b0, 8'h00, w);

    // Back-to-back with req_valid held through the busy period.
    xfer(1'b1, 8'h45, 1'b1, 1'b1, 8'h4C, w);
    xfer(1'b1, 8'h4C, 1'b0, 1'b0, 8'h00, w);
    chk("b2b_first_idle_accept", w, 0);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      r = 1'($urandom_range(0, 1));
      if (r) begin
        d = 8'($urandom_range(32, 126));
      end else begin
        d = cmd_tab[$urandom_range(0, 7)];
        if (d[7]) d = d + 8'($urandom_range(0, 15));
      end
      xfer(r, d, 1'b0, 1'b0, 8'h00, w);
    end

    // Seventeen characters from the home position.
    xfer(1'b0, 8'h01, 1'b0, 1'b0, 8'h00, w);
    for (int i = 0; i < 17; i++) xfer(1'b1, 8'h41 + 8'(i), 1'b0, 1'b0, 8'h00, w);

    // Reset during the high nibble's enable-high window.
    req_valid = 1'b1;
    req_rs    = 1'b1;
    req_data  = 8'h5A;
    w = 0;
    while (!req_ready && w < 20000) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    w = 0;
    while (!lcd_en && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("mid_op_en_seen", lcd_en, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_op_en_off", lcd_en, 0);
    chk("mid_op_init_done", init_done, 0);
    chk("mid_op_ready", req_ready, 0);
    repeat (3) @(negedge clk);
    chk("mid_op_data_clr", lcd_data, 0);
    chk("mid_op_busy", busy, 0);
    chk("mid_op_q_empty", exp_q.size(), 0);

    do_init();
    xfer(1'b1, 8'h4F, 1'b0, 1'b0, 8'h00, w);
    xfer(1'b1, 8'h4B, 1'b0, 1'b0, 8'h00, w);

    repeat (10) @(negedge clk);
    chk("final_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
